// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte FIFO in front of a UART transmitter. Bytes pushed from the bus side
// are launched one at a time with a single-cycle transmit pulse.
// Each launch waits for the UART busy flag to rise and then fall before the
// next byte is popped.
// All outputs come from registers or decode of registers. No input reaches
// an output combinationally.
module uart_tx_queue #(
   parameter int DEPTH  = 16,  // power of two, at least 2
   parameter int ADDR_W = 4    // log2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   input  logic              clr_overflow,
   output logic              uart_transmit,
   output logic [7:0]        uart_tx_byte,
   input  logic              uart_is_transmitting,
   output logic              busy
);

   localparam int LVL_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_LAUNCH     = 2'd1,
      S_WAIT_START = 2'd2,
      S_WAIT_DONE  = 2'd3
   } state_t;

   // Storage and bookkeeping
   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_overflow;

   // Sequencer
   state_t            r_state;
   logic              r_transmit;
   logic [7:0]        r_tx_byte;

   // Decoded controls
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   state_t            w_state_next;
   logic [LVL_W-1:0]  w_level_next;

   // Occupancy flags decode from the registered level only, so a pop in the
   // same cycle never makes room for a push that arrives while full.
   assign w_full  = (r_level == LVL_W'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_push  = wr_en && !w_full;
   assign w_drop  = wr_en && w_full;

   // Next-state and pop decision for the launch sequencer
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Never hand a byte to a UART that is still shifting one out.
            if (!w_empty && !uart_is_transmitting) begin
               w_pop        = 1'b1;
               w_state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_state_next = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (uart_is_transmitting) begin
               w_state_next = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (!uart_is_transmitting) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Level follows push/pop; a simultaneous push and pop leaves it unchanged
   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_pop) begin
         w_level_next = r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
         w_level_next = r_level - LVL_W'(1);
      end
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FIFO data array: write port only, no reset so it maps onto RAM
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally modulo DEPTH; level is tracked separately
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_level <= w_level_next;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   // Launch pulse and byte register; the byte is the RAM's registered read
   // and only changes on a pop, so it holds through the whole handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_transmit <= 1'b0;
         r_tx_byte  <= 8'h00;
      end else begin
         r_transmit <= w_pop;
         if (w_pop) begin
            r_tx_byte <= r_mem[r_rd_ptr];
         end
      end
   end

   assign full          = w_full;
   assign empty         = w_empty;
   assign level         = r_level;
   assign overflow      = r_overflow;
   assign uart_transmit = r_transmit;
   assign uart_tx_byte  = r_tx_byte;
   assign busy          = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a simple UART busy-flag model plus a scoreboard of
// expected launched bytes, a vector table for the fill/overflow sequence and
// hand-written sequences for timing, wrap and reset corner cases.
module tb_uart_tx_queue;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int FRAME  = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          clr_overflow = 1'b0;
   logic          uart_is_transmitting = 1'b0;
   logic          full;
   logic          empty;
   logic [ADDR_W:0] level;
   logic          overflow;
   logic          uart_transmit;
   logic [7:0]    uart_tx_byte;
   logic          busy;

   int            n_checks = 0;
   int            n_errors = 0;
   int            pulse_cnt = 0;
   int            exp_pulses = 0;
   int            frame_cnt = 0;
   logic          hold_busy = 1'b0;
   logic [7:0]    sb [$];

   logic          mon_prev_tx = 1'b0;
   logic [7:0]    mon_held = 8'h00;
   logic [7:0]    mon_exp = 8'h00;

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       clr;
      int         lvl;
      logic       full;
      logic       ovf;
      logic       acc;
   } vec_t;

   vec_t vecs [20];

   uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .wr_en                (wr_en),
      .wr_data              (wr_data),
      .full                 (full),
      .empty                (empty),
      .level                (level),
      .overflow             (overflow),
      .clr_overflow         (clr_overflow),
      .uart_transmit        (uart_transmit),
      .uart_tx_byte         (uart_tx_byte),
      .uart_is_transmitting (uart_is_transmitting),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   // UART model: busy for FRAME cycles starting the cycle after a launch,
   // or forced busy while hold_busy is set
   always @(posedge clk) begin
      if (rst) begin
         uart_is_transmitting <= 1'b0;
         frame_cnt            <= 0;
      end else if (hold_busy) begin
         uart_is_transmitting <= 1'b1;
         frame_cnt            <= 0;
      end else if (uart_transmit && !uart_is_transmitting) begin
         uart_is_transmitting <= 1'b1;
         frame_cnt            <= FRAME - 1;
      end else if (uart_is_transmitting) begin
         if (frame_cnt == 0) uart_is_transmitting <= 1'b0;
         else                frame_cnt <= frame_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || uart_is_transmitting) && n < budget) begin
         tick();
         n++;
      end
      check("drain_within_budget", 32'(n < budget), 32'd1);
   endtask

   // Output monitor: every launch pulse is one cycle wide, never overlaps a
   // busy UART, carries the next scoreboard byte; the byte is otherwise stable
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_prev_tx = 1'b0;
            mon_held    = 8'h00;
         end else begin
            if (uart_transmit) begin
               pulse_cnt++;
               check("pulse_width_prev", 32'(mon_prev_tx), 32'd0);
               check("launch_while_uart_busy", 32'(uart_is_transmitting), 32'd0);
               n_checks++;
               if (sb.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_pulse: byte %02h launched, scoreboard empty (t=%0t)",
                           uart_tx_byte, $time);
               end else begin
                  mon_exp = sb.pop_front();
                  if (uart_tx_byte !== mon_exp) begin
                     n_errors++;
                     $display("FAIL tx_byte_order: got %02h expected %02h (t=%0t)",
                              uart_tx_byte, mon_exp, $time);
                  end
               end
               mon_held = uart_tx_byte;
            end else begin
               check("tx_byte_stable", 32'(uart_tx_byte), 32'(mon_held));
            end
            mon_prev_tx = uart_transmit;
         end
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int m_level;
      int idx;
      int n;
      logic pushed;

      // Vector table: fill to DEPTH with the UART held busy, then overflow
      for (int i = 0; i < 17; i++) begin
         vecs[i].wr   = 1'b1;
         vecs[i].data = 8'(8'h80 + i);
         vecs[i].clr  = 1'b0;
         vecs[i].lvl  = (i + 1 > DEPTH) ? DEPTH : i + 1;
         vecs[i].full = (i >= DEPTH - 1);
         vecs[i].ovf  = (i == DEPTH);
         vecs[i].acc  = (i < DEPTH);
      end
      vecs[17] = '{wr: 1'b0, data: 8'h00, clr: 1'b1, lvl: DEPTH, full: 1'b1, ovf: 1'b0, acc: 1'b0};
      vecs[18] = '{wr: 1'b1, data: 8'hEE, clr: 1'b1, lvl: DEPTH, full: 1'b1, ovf: 1'b1, acc: 1'b0};
      vecs[19] = '{wr: 1'b0, data: 8'h00, clr: 1'b1, lvl: DEPTH, full: 1'b1, ovf: 1'b0, acc: 1'b0};

      // ---- Reset then idle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_full", 32'(full), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_transmit", 32'(uart_transmit), 32'd0);
      check("reset_tx_byte", 32'(uart_tx_byte), 32'h00);
      check("reset_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 10; i++) tick();
      check("idle_no_pulse", 32'(pulse_cnt), 32'd0);

      // ---- Single byte with cycle-exact timing
      wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5); exp_pulses++;
      tick();                                  // now in cycle 1
      wr_en = 1'b0;
      check("single_c1_level", 32'(level), 32'd1);
      check("single_c1_empty", 32'(empty), 32'd0);
      check("single_c1_transmit", 32'(uart_transmit), 32'd0);
      check("single_c1_busy", 32'(busy), 32'd1);
      tick();                                  // cycle 2
      check("single_c2_transmit", 32'(uart_transmit), 32'd1);
      check("single_c2_tx_byte", 32'(uart_tx_byte), 32'hA5);
      check("single_c2_level", 32'(level), 32'd0);
      check("single_c2_busy", 32'(busy), 32'd1);
      tick();                                  // cycle 3
      check("single_c3_transmit", 32'(uart_transmit), 32'd0);
      check("single_c3_uart_busy", 32'(uart_is_transmitting), 32'd1);
      wait_idle(FRAME * 3);
      check("single_done_busy", 32'(busy), 32'd0);
      check("single_done_tx_byte", 32'(uart_tx_byte), 32'hA5);
      check("single_pulses", 32'(pulse_cnt), 32'(exp_pulses));

      // ---- Burst 01..10 with UART held busy so the FIFO fills, then drain
      hold_busy = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1'b1; wr_data = 8'(i + 1);
         sb.push_back(8'(i + 1)); exp_pulses++;
         tick();
      end
      wr_en = 1'b0;
      check("burst_full", 32'(full), 32'd1);
      check("burst_level", 32'(level), 32'(DEPTH));
      check("burst_overflow", 32'(overflow), 32'd0);
      hold_busy = 1'b0;
      wait_idle(DEPTH * (FRAME + 10));
      check("burst_pulses", 32'(pulse_cnt), 32'(exp_pulses));
      check("burst_level_end", 32'(level), 32'd0);

      // ---- Overflow vector table with UART held busy
      hold_busy = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         wr_en = vecs[i].wr; wr_data = vecs[i].data; clr_overflow = vecs[i].clr;
         if (vecs[i].acc) begin
            sb.push_back(vecs[i].data);
            exp_pulses++;
         end
         tick();
         wr_en = 1'b0; clr_overflow = 1'b0;
         check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
         check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].full));
         check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      end
      hold_busy = 1'b0;
      wait_idle(DEPTH * (FRAME + 10));
      check("ovf_pulses", 32'(pulse_cnt), 32'(exp_pulses));

      // ---- Wrap: stream 40 bytes, push whenever the model says not full
      check("wrap_start_level", 32'(level), 32'd0);
      m_level = 0;
      idx = 0;
      n = 0;
      while ((idx < 40 || sb.size() != 0 || busy || uart_is_transmitting) && n < 5000) begin
         pushed = (idx < 40) && (m_level < DEPTH);
         if (pushed) begin
            wr_en = 1'b1; wr_data = 8'(idx);
            sb.push_back(8'(idx)); exp_pulses++;
            idx++;
         end
         tick();
         wr_en = 1'b0;
         m_level = m_level + (pushed ? 1 : 0) - (uart_transmit ? 1 : 0);
         check("wrap_level", 32'(level), 32'(m_level));
         check("wrap_full", 32'(full), 32'(m_level == DEPTH));
         check("wrap_empty", 32'(empty), 32'(m_level == 0));
         n++;
      end
      check("wrap_within_budget", 32'(n < 5000), 32'd1);
      check("wrap_pulses", 32'(pulse_cnt), 32'(exp_pulses));

      // ---- Reset mid-transfer
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
         sb.push_back(8'(8'hC0 + i)); exp_pulses++;
         tick();
      end
      wr_en = 1'b0;
      n = 0;
      while (!uart_is_transmitting && n < 20) begin
         tick();
         n++;
      end
      check("midrst_uart_started", 32'(uart_is_transmitting), 32'd1);
      tick();
      tick();                                  // sequencer now waiting for done
      rst = 1'b1;
      exp_pulses = exp_pulses - sb.size();     // queued bytes are discarded
      sb.delete();
      tick();
      rst = 1'b0;
      check("midrst_transmit", 32'(uart_transmit), 32'd0);
      check("midrst_level", 32'(level), 32'd0);
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_tx_byte", 32'(uart_tx_byte), 32'h00);
      for (int i = 0; i < 5; i++) tick();
      check("midrst_no_pulse", 32'(pulse_cnt), 32'(exp_pulses));
      wr_en = 1'b1; wr_data = 8'h5A; sb.push_back(8'h5A); exp_pulses++;
      tick();
      wr_en = 1'b0;
      wait_idle(FRAME * 3);
      check("midrst_after_tx_byte", 32'(uart_tx_byte), 32'h5A);
      check("midrst_after_pulses", 32'(pulse_cnt), 32'(exp_pulses));
      check("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
